// File: rtl/hazard_track.sv
// Hazard tracking for a predicated in-order pipeline: carries destination/write/predicate
// fields through EX, MEM and WB, drives PC/IF-ID enables, and counts stall and flush events.
module hazard_track (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rd_ID,
    input  logic        RegWrite_ID,
    input  logic        MemRead_ID,
    input  logic        RPzero_ID,
    input  logic        Valid_ID,
    input  logic        Stall,
    input  logic        Flush,
    output logic [4:0]  Rd_EX,
    output logic [4:0]  Rd_MEM,
    output logic [4:0]  Rd_WB,
    output logic        RegWrite_EX,
    output logic        RegWrite_MEM,
    output logic        RegWrite_WB,
    output logic        RPzero_EX,
    output logic        RPzero_MEM,
    output logic        RPzero_WB,
    output logic        MemRead_EX,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic [15:0] Stall_Count,
    output logic [15:0] Flush_Count,
    output logic        Stall_Err
);

    logic        stall_eff_s;
    logic        bubble_s;
    logic        flush_s;

    logic [4:0]  rd_ex_r,  rd_mem_r,  rd_wb_r;
    logic        rw_ex_r,  rw_mem_r,  rw_wb_r;
    logic        rp_ex_r,  rp_mem_r,  rp_wb_r;
    logic        mr_ex_r,  mr_mem_r;
    logic [15:0] stall_count_r;
    logic [15:0] flush_count_r;
    logic        stall_err_r;
    logic        stall_hist_r;

    // Qualify stall/flush requests; everything is masked while reset is held
    always_comb begin
        stall_eff_s = 1'b0;
        flush_s     = 1'b0;
        bubble_s    = 1'b1;
        if (rst) begin
            stall_eff_s = 1'b0;
            flush_s     = 1'b0;
            bubble_s    = 1'b1;
        end else begin
            stall_eff_s = Stall & ~Flush;
            flush_s     = Flush;
            bubble_s    = (Stall & ~Flush) | Flush | ~Valid_ID;
        end
    end

    // Tracked-field pipeline; downstream stages always advance, even under a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ex_r  <= 5'd0;  rd_mem_r <= 5'd0;  rd_wb_r <= 5'd0;
            rw_ex_r  <= 1'b0;  rw_mem_r <= 1'b0;  rw_wb_r <= 1'b0;
            rp_ex_r  <= 1'b0;  rp_mem_r <= 1'b0;  rp_wb_r <= 1'b0;
            mr_ex_r  <= 1'b0;  mr_mem_r <= 1'b0;
        end else begin
            rd_wb_r  <= rd_mem_r;
            rw_wb_r  <= rw_mem_r;
            rp_wb_r  <= rp_mem_r;
            rd_mem_r <= rd_ex_r;
            rw_mem_r <= rw_ex_r;
            rp_mem_r <= rp_ex_r;
            mr_mem_r <= mr_ex_r;
            if (bubble_s) begin
                rd_ex_r <= 5'd0;
                rw_ex_r <= 1'b0;
                mr_ex_r <= 1'b0;
                rp_ex_r <= 1'b0;
            end else begin
                // Killed instructions (RPzero_ID=0) keep their Rd so forwarding can see them
                rd_ex_r <= Rd_ID;
                rw_ex_r <= RegWrite_ID;
                mr_ex_r <= MemRead_ID;
                rp_ex_r <= RPzero_ID;
            end
        end
    end

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= 16'd0;
            flush_count_r <= 16'd0;
        end else begin
            if (stall_eff_s && (stall_count_r != 16'hFFFF)) begin
                stall_count_r <= stall_count_r + 16'd1;
            end
            if (flush_s && (flush_count_r != 16'hFFFF)) begin
                flush_count_r <= flush_count_r + 16'd1;
            end
        end
    end

    // A legal load-use stall lasts one cycle; back-to-back stalls latch a sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_hist_r <= 1'b0;
            stall_err_r  <= 1'b0;
        end else begin
            stall_hist_r <= stall_eff_s;
            if (stall_eff_s && stall_hist_r) begin
                stall_err_r <= 1'b1;
            end
        end
    end

    assign PC_Write     = ~rst & ~stall_eff_s;
    assign IFID_Write   = ~rst & ~stall_eff_s;
    assign IFID_Flush   = flush_s;

    assign Rd_EX        = rd_ex_r;
    assign Rd_MEM       = rd_mem_r;
    assign Rd_WB        = rd_wb_r;
    assign RegWrite_EX  = rw_ex_r;
    assign RegWrite_MEM = rw_mem_r;
    assign RegWrite_WB  = rw_wb_r;
    assign RPzero_EX    = rp_ex_r;
    assign RPzero_MEM   = rp_mem_r;
    assign RPzero_WB    = rp_wb_r;
    assign MemRead_EX   = mr_ex_r;
    assign Stall_Count  = stall_count_r;
    assign Flush_Count  = flush_count_r;
    assign Stall_Err    = stall_err_r;

endmodule

// File: tb/tb_hazard_track.sv
// Directed self-checking bench for hazard_track; inputs change on the falling edge,
// registered outputs are sampled on the following falling edge.
module tb_hazard_track;

    logic        clk;
    logic        rst;
    logic [4:0]  Rd_ID;
    logic        RegWrite_ID, MemRead_ID, RPzero_ID, Valid_ID, Stall, Flush;
    logic [4:0]  Rd_EX, Rd_MEM, Rd_WB;
    logic        RegWrite_EX, RegWrite_MEM, RegWrite_WB;
    logic        RPzero_EX, RPzero_MEM, RPzero_WB;
    logic        MemRead_EX, PC_Write, IFID_Write, IFID_Flush;
    logic [15:0] Stall_Count, Flush_Count;
    logic        Stall_Err;

    int checks_s   = 0;
    int failures_s = 0;

    hazard_track dut (
        .clk(clk), .rst(rst),
        .Rd_ID(Rd_ID), .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID),
        .RPzero_ID(RPzero_ID), .Valid_ID(Valid_ID), .Stall(Stall), .Flush(Flush),
        .Rd_EX(Rd_EX), .Rd_MEM(Rd_MEM), .Rd_WB(Rd_WB),
        .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
        .RPzero_EX(RPzero_EX), .RPzero_MEM(RPzero_MEM), .RPzero_WB(RPzero_WB),
        .MemRead_EX(MemRead_EX), .PC_Write(PC_Write), .IFID_Write(IFID_Write),
        .IFID_Flush(IFID_Flush), .Stall_Count(Stall_Count), .Flush_Count(Flush_Count),
        .Stall_Err(Stall_Err)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_s++;
        if (obs !== exp) begin
            failures_s++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rd, input logic rw,
                            input logic mr, input logic rp);
        Valid_ID    = v;
        Rd_ID       = rd;
        RegWrite_ID = rw;
        MemRead_ID  = mr;
        RPzero_ID   = rp;
    endtask

    // Directed scenarios
    initial begin
        rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        drive_id(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check_val("pcw_in_rst", {31'd0, PC_Write}, 32'd0);
        tick();
        check_val("rst_rd_ex", {27'd0, Rd_EX}, 32'd0);
        check_val("rst_stall_cnt", {16'd0, Stall_Count}, 32'd0);
        check_val("rst_err", {31'd0, Stall_Err}, 32'd0);

        // Single instruction flows EX -> MEM -> WB
        rst = 1'b0;
        drive_id(1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        #1;
        check_val("pcw_run", {31'd0, PC_Write}, 32'd1);
        tick();
        drive_id(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("rd_ex_5", {27'd0, Rd_EX}, 32'd5);
        check_val("rw_ex_5", {31'd0, RegWrite_EX}, 32'd1);
        check_val("rp_ex_5", {31'd0, RPzero_EX}, 32'd1);
        tick();
        check_val("rd_mem_5", {27'd0, Rd_MEM}, 32'd5);
        check_val("rw_mem_5", {31'd0, RegWrite_MEM}, 32'd1);
        check_val("rd_ex_bub", {27'd0, Rd_EX}, 32'd0);
        tick();
        check_val("rd_wb_5", {27'd0, Rd_WB}, 32'd5);
        check_val("rw_wb_5", {31'd0, RegWrite_WB}, 32'd1);
        check_val("rp_wb_5", {31'd0, RPzero_WB}, 32'd1);

        // Load followed by a one-cycle load-use stall
        drive_id(1'b1, 5'd7, 1'b1, 1'b1, 1'b1);
        tick();
        check_val("ld_rd_ex", {27'd0, Rd_EX}, 32'd7);
        check_val("ld_mr_ex", {31'd0, MemRead_EX}, 32'd1);
        drive_id(1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
        Stall = 1'b1;
        #1;
        check_val("stall_pcw", {31'd0, PC_Write}, 32'd0);
        check_val("stall_ifidw", {31'd0, IFID_Write}, 32'd0);
        tick();
        Stall = 1'b0;
        drive_id(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("stall_ex_bub", {27'd0, Rd_EX}, 32'd0);
        check_val("stall_mr_bub", {31'd0, MemRead_EX}, 32'd0);
        check_val("stall_rd_mem", {27'd0, Rd_MEM}, 32'd7);
        check_val("stall_cnt1", {16'd0, Stall_Count}, 32'd1);
        check_val("stall_err0", {31'd0, Stall_Err}, 32'd0);

        // Simultaneous stall and flush: flush wins
        drive_id(1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
        Stall = 1'b1; Flush = 1'b1;
        #1;
        check_val("sf_pcw", {31'd0, PC_Write}, 32'd1);
        check_val("sf_ifidf", {31'd0, IFID_Flush}, 32'd1);
        tick();
        Stall = 1'b0; Flush = 1'b0;
        drive_id(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check_val("sf_ifidf_off", {31'd0, IFID_Flush}, 32'd0);
        check_val("sf_rd_ex", {27'd0, Rd_EX}, 32'd0);
        check_val("sf_flush_cnt", {16'd0, Flush_Count}, 32'd1);
        check_val("sf_stall_cnt", {16'd0, Stall_Count}, 32'd1);
        check_val("sf_err", {31'd0, Stall_Err}, 32'd0);

        // Two consecutive stalls raise the sticky error
        Stall = 1'b1;
        tick();
        check_val("cs_cnt2", {16'd0, Stall_Count}, 32'd2);
        check_val("cs_err_first", {31'd0, Stall_Err}, 32'd0);
        tick();
        Stall = 1'b0;
        check_val("cs_cnt3", {16'd0, Stall_Count}, 32'd3);
        check_val("cs_err_set", {31'd0, Stall_Err}, 32'd1);
        tick();
        check_val("cs_err_sticky", {31'd0, Stall_Err}, 32'd1);

        // Killed instruction keeps its Rd
        drive_id(1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        drive_id(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("kill_rd_ex", {27'd0, Rd_EX}, 32'd12);
        check_val("kill_rp_ex", {31'd0, RPzero_EX}, 32'd0);
        check_val("kill_rw_ex", {31'd0, RegWrite_EX}, 32'd1);

        // Mid-operation reset with Rd_MEM=3 in flight; inputs ignored during reset
        drive_id(1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
        tick();
        drive_id(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("pre_rst_mem", {27'd0, Rd_MEM}, 32'd3);
        rst = 1'b1;
        Stall = 1'b1; Flush = 1'b1;
        drive_id(1'b1, 5'd20, 1'b1, 1'b0, 1'b1);
        #1;
        check_val("rst_pcw", {31'd0, PC_Write}, 32'd0);
        check_val("rst_ifidw", {31'd0, IFID_Write}, 32'd0);
        check_val("rst_ifidf", {31'd0, IFID_Flush}, 32'd0);
        tick();
        check_val("rst2_rd_ex", {27'd0, Rd_EX}, 32'd0);
        check_val("rst2_rd_mem", {27'd0, Rd_MEM}, 32'd0);
        check_val("rst2_rd_wb", {27'd0, Rd_WB}, 32'd0);
        check_val("rst2_rw", {29'd0, RegWrite_EX, RegWrite_MEM, RegWrite_WB}, 32'd0);
        check_val("rst2_rp", {29'd0, RPzero_EX, RPzero_MEM, RPzero_WB}, 32'd0);
        check_val("rst2_mr", {31'd0, MemRead_EX}, 32'd0);
        check_val("rst2_scnt", {16'd0, Stall_Count}, 32'd0);
        check_val("rst2_fcnt", {16'd0, Flush_Count}, 32'd0);
        check_val("rst2_err", {31'd0, Stall_Err}, 32'd0);
        rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
        #1;
        check_val("post_rst_pcw", {31'd0, PC_Write}, 32'd1);
        tick();
        drive_id(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("post_rst_cap", {27'd0, Rd_EX}, 32'd20);

        // Saturation from a forced preload, with two separated stalls
        force dut.stall_count_r = 16'hFFFE;
        #1;
        release dut.stall_count_r;
        Stall = 1'b1;
        tick();
        Stall = 1'b0;
        check_val("sat_ffff", {16'd0, Stall_Count}, 32'h0000FFFF);
        tick();
        Stall = 1'b1;
        tick();
        Stall = 1'b0;
        check_val("sat_hold", {16'd0, Stall_Count}, 32'h0000FFFF);
        tick();
        check_val("sat_hold2", {16'd0, Stall_Count}, 32'h0000FFFF);
        check_val("sat_err0", {31'd0, Stall_Err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
        $finish;
    end

endmodule

// File: doc/hazard_track.md
HAZARD_TRACK -- requirements
Module: hazard_track

Interface
REQ-001 SHALL have no parameters; register index width is fixed at 5, counter width at 16.
REQ-002 clk  in  1  rising-edge clock; sole clock domain.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 Rd_ID  in  5  destination register of the instruction currently in ID.
REQ-005 RegWrite_ID, MemRead_ID  in  1 each  register-write / load flags of the ID instruction.
REQ-006 RPzero_ID  in  1  predicate of the ID instruction: 1 = commits, 0 = killed.
REQ-007 Valid_ID  in  1  IF/ID holds a real instruction.
REQ-008 Stall  in  1  load-use stall request from the hazard unit.
REQ-009 Flush  in  1  control-transfer redirect; kills the instruction in ID.
REQ-010 Rd_EX, Rd_MEM, Rd_WB  out  5 each  tracked destination registers.
REQ-011 RegWrite_EX, RegWrite_MEM, RegWrite_WB  out  1 each  tracked write enables.
REQ-012 RPzero_EX, RPzero_MEM, RPzero_WB  out  1 each  tracked predicates; 1 = commits.
REQ-013 MemRead_EX  out  1  instruction in EX is a load.
REQ-014 PC_Write, IFID_Write  out  1 each  PC and IF/ID register enables.
REQ-015 IFID_Flush  out  1  clear IF/ID.
REQ-016 Stall_Count, Flush_Count  out  16 each  saturating event counters.
REQ-017 Stall_Err  out  1  sticky protocol-error flag.

Function
REQ-018 Stall_eff SHALL equal Stall AND NOT Flush; Flush wins on simultaneous Stall and Flush.
REQ-019 Bubble SHALL equal Stall_eff OR Flush OR NOT Valid_ID.
REQ-020 Each rising edge SHALL shift all tracked fields: WB<-MEM, MEM<-EX, unconditionally. A stall never freezes EX/MEM/WB.
REQ-021 On Bubble, EX SHALL load Rd=0, RegWrite=0, MemRead=0, RPzero=0.
REQ-022 Otherwise, EX SHALL load Rd_ID, RegWrite_ID, MemRead_ID, RPzero_ID unchanged; a killed instruction (RPzero_ID=0) is carried with its Rd intact.
REQ-023 The MEM stage SHALL carry MemRead internally; it is not an output.
REQ-024 PC_Write and IFID_Write SHALL equal NOT Stall_eff, combinationally. Both SHALL be 0 while rst=1.
REQ-025 IFID_Flush SHALL equal Flush, combinationally. It SHALL be 0 while rst=1.
REQ-026 Latency: ID fields SHALL appear on the EX outputs 1 cycle after capture, on MEM after 2, on WB after 3.
REQ-027 Stall_Count SHALL increment by 1 each cycle Stall_eff=1 and hold at 16'hFFFF; no wrap.
REQ-028 Flush_Count SHALL increment by 1 each cycle Flush=1 and hold at 16'hFFFF; no wrap.
REQ-029 Consecutive-stall tracking:
- a 1-bit register SHALL record Stall_eff from the previous cycle;
- Stall_Err SHALL set on the edge where Stall_eff=1 and the recorded bit =1;
- rationale: a legal load-use stall lasts exactly 1 cycle.
REQ-030 Stall_Err SHALL remain 1 until rst and SHALL NOT otherwise affect tracking.
REQ-031 All outputs other than PC_Write, IFID_Write and IFID_Flush SHALL be registered.

Reset
REQ-032 On the edge where rst=1, the following SHALL all clear to 0:
- Rd_*, RegWrite_*, RPzero_*, MemRead_EX, the internal MEM MemRead;
- both counters, Stall_Err, and the stall-history bit.
REQ-033 Reset mid-operation SHALL discard all in-flight entries. The first post-reset edge SHALL capture ID normally.
REQ-034 Stall, Flush and the ID inputs SHALL be ignored while rst=1.

Verification
REQ-035 Scenario: Valid_ID=1, Rd_ID=5, RegWrite_ID=1, RPzero_ID=1, no Stall or Flush, for 1 cycle, then Valid_ID=0 -> Rd_EX=5 at +1, Rd_MEM=5 at +2, Rd_WB=5 at +3, RegWrite follows, Rd_EX=0 at +2.
REQ-036 Scenario: load (MemRead_ID=1, Rd_ID=7) followed by Stall=1 for 1 cycle -> during the stall PC_Write=0, IFID_Write=0, EX=bubble; next cycle Rd_MEM=7; Stall_Count=1; Stall_Err=0.
REQ-037 Scenario: Stall=1 for 2 consecutive cycles -> Stall_Err=1 after the 2nd edge; it stays 1 after Stall drops and until rst; Stall_Count=2.
REQ-038 Scenario: Stall=1 and Flush=1 together, Rd_ID=9 -> PC_Write=1, IFID_Flush=1, Rd_EX=0 next cycle; Flush_Count=1, Stall_Count=0.
REQ-039 Scenario: Stall_Count preloaded to 16'hFFFE by forcing, then two non-consecutive stalls -> count reads 16'hFFFF and holds.
REQ-040 Scenario: rst=1 for 1 cycle while Rd_MEM=3 -> all tracked fields, counters and Stall_Err read 0; PC_Write=0 during rst and =1 after rst drops.
